// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_func3;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic [4:0]      req_rd;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            busy;

    modport master (
        output req_valid, req_func3, req_src1, req_src2, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd, busy
    );

    modport slave (
        input  req_valid, req_func3, req_src1, req_src2, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: 34 edges accept->resp_valid; div-by-zero/overflow take 2 edges when FAST_SPEC=1.
// Backpressure: one op in flight; req_ready only in IDLE, result held in DONE until resp_ready.
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    muldiv_sequencer_if.slave io
);
    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     counter;
    logic [2:0]        func3_q;
    logic              res_neg;
    logic              special;
    logic [XLEN-1:0]   spec_val;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [2*XLEN-1:0] prod;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_data_q;
    logic [4:0]        resp_rd_q;

    // Request decode: operand magnitudes, result sign and the special cases
    logic            s1_signed, s2_signed, neg1, neg2;
    logic            div_zero, div_ovf, spec_now, res_neg_now;
    logic [XLEN-1:0] mag1, mag2, spec_now_val;

    always_comb begin
        s1_signed    = (io.req_func3 == 3'b001) || (io.req_func3 == 3'b010) ||
                       (io.req_func3[2] && !io.req_func3[0]);
        s2_signed    = (io.req_func3 == 3'b001) || (io.req_func3[2] && !io.req_func3[0]);
        neg1         = s1_signed && io.req_src1[XLEN-1];
        neg2         = s2_signed && io.req_src2[XLEN-1];
        mag1         = neg1 ? -io.req_src1 : io.req_src1;
        mag2         = neg2 ? -io.req_src2 : io.req_src2;
        res_neg_now  = (io.req_func3 == 3'b110) ? neg1 : (neg1 ^ neg2);
        div_zero     = io.req_func3[2] && (io.req_src2 == '0);
        div_ovf      = io.req_func3[2] && !io.req_func3[0] &&
                       (io.req_src1 == MIN_INT) && (io.req_src2 == '1);
        spec_now     = div_zero || div_ovf;
        if (div_zero) spec_now_val = io.req_func3[1] ? io.req_src1 : '1;
        else          spec_now_val = io.req_func3[1] ? '0 : MIN_INT;
    end

    // One iteration step of each datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_part;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, op_a};
        div_part = {rem, quo[XLEN-1]};
        div_ge   = (div_part >= {1'b0, op_b});
        // When div_ge holds the true difference is below op_b, so the low bits suffice
        div_diff = div_part[XLEN-1:0] - op_b;
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    always_comb begin
        prod_fix = res_neg ? -prod : prod;
        quo_fix  = res_neg ? -quo  : quo;
        rem_fix  = res_neg ? -rem  : rem;
        case (func3_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fix;
            default:                fix_val = rem_fix;
        endcase
        if (special) fix_val = spec_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            func3_q      <= '0;
            res_neg      <= 1'b0;
            special      <= 1'b0;
            spec_val     <= '0;
            op_a         <= '0;
            op_b         <= '0;
            quo          <= '0;
            rem          <= '0;
            prod         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
        end else if (flush) begin
            state        <= IDLE;
            counter      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.req_valid) begin
                        func3_q   <= io.req_func3;
                        res_neg   <= res_neg_now;
                        special   <= spec_now;
                        spec_val  <= spec_now_val;
                        op_a      <= mag1;
                        op_b      <= mag2;
                        quo       <= mag1;
                        rem       <= '0;
                        prod      <= {{XLEN{1'b0}}, mag2};
                        resp_rd_q <= io.req_rd;
                        counter   <= '0;
                        state     <= (FAST_SPEC && spec_now) ? FIX : ITER;
                    end
                end
                ITER: begin
                    if (func3_q[2]) begin
                        rem <= div_ge ? div_diff : div_part[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], div_ge};
                    end else begin
                        prod <= prod[0] ? {mul_sum, prod[XLEN-1:1]}
                                        : {1'b0, prod[2*XLEN-1:1]};
                    end
                    counter <= counter + 1'b1;
                    if (counter == CW'(XLEN - 1)) state <= FIX;
                end
                FIX: begin
                    resp_data_q  <= fix_val;
                    resp_valid_q <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (io.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.req_ready  = (state == IDLE) && !flush;
    assign io.busy       = (state != IDLE);
    assign io.resp_valid = resp_valid_q;
    assign io.resp_data  = resp_data_q;
    assign io.resp_rd    = resp_rd_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboarded bench for muldiv_sequencer: directed RV32M vectors, latency, hold, flush and reset.
module tb_muldiv_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    muldiv_sequencer_if #(.XLEN(32)) io ();

    muldiv_sequencer #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (io)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is popped and compared
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (rst_n && io.resp_valid && io.resp_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got rd %0d data %h expected no response",
                             io.resp_rd, io.resp_data);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", io.resp_data, e.data);
                    check("resp_rd", {27'd0, io.resp_rd}, {27'd0, e.rd});
                end
            end
        end
    end

    // Issue one request, push its expectation and measure edges from accept to resp_valid
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                         input string name);
        int lat;
        bit seen;
        for (int i = 0; i < 100 && !io.req_ready; i++) begin
            @(posedge clk);
            #1;
        end
        io.req_valid = 1'b1;
        io.req_func3 = f3;
        io.req_src1  = a;
        io.req_src2  = b;
        io.req_rd    = rd;
        sb.push_back({exp, rd});
        @(posedge clk);
        #1;
        io.req_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (io.resp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no resp_valid within 60 cycles, expected latency %0d",
                     name, exp_lat);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        end
        if (io.resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a request that is expected to be aborted (nothing pushed)
    task automatic start_raw(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        io.req_valid = 1'b1;
        io.req_func3 = f3;
        io.req_src1  = a;
        io.req_src2  = b;
        io.req_rd    = 5'd31;
        @(posedge clk);
        #1;
        io.req_valid = 1'b0;
    endtask

    initial begin
        io.req_valid  = 1'b0;
        io.req_func3  = 3'b000;
        io.req_src1   = '0;
        io.req_src2   = '0;
        io.req_rd     = '0;
        io.resp_ready = 1'b1;

        #2 rst_n = 1'b0;
        #20;
        check("rst_resp_valid", io.resp_valid, 1'b0);
        check("rst_resp_data", io.resp_data, 32'h0);
        check("rst_resp_rd", {27'd0, io.resp_rd}, 32'h0);
        check("rst_busy", io.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", io.req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Multiplies
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, "mul_7_m3");
        issue(3'b001, 32'd7, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFF, 34, "mulh_7_m3");
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 34, "mulhu_max");
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 34, "mulhsu_m1");
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 34, "mulh_min");
        issue(3'b000, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h0000_0000, 34, "mul_min");

        // Divides
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34, "div_m7_2");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34, "rem_m7_2");
        issue(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 34, "divu_100_7");
        issue(3'b111, 32'd100, 32'd7, 5'd10, 32'd2, 34, "remu_100_7");
        issue(3'b100, 32'd20, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFA, 34, "div_20_m3");
        issue(3'b110, 32'd20, 32'hFFFF_FFFD, 5'd12, 32'd2, 34, "rem_20_m3");
        issue(3'b110, 32'hFFFF_FFEC, 32'd3, 5'd13, 32'hFFFF_FFFE, 34, "rem_m20_3");

        // Special cases resolved on the fast path
        issue(3'b100, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 2, "div_by0");
        issue(3'b110, 32'd5, 32'd0, 5'd15, 32'd5, 2, "rem_by0");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2, "div_ovf");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 2, "rem_ovf");
        issue(3'b101, 32'd5, 32'd0, 5'd18, 32'hFFFF_FFFF, 2, "divu_by0");
        issue(3'b111, 32'h0000_1234, 32'd0, 5'd19, 32'h0000_1234, 2, "remu_by0");

        // Result held under backpressure
        io.resp_ready = 1'b0;
        issue(3'b000, 32'd6, 32'd9, 5'd21, 32'd54, 34, "hold_mul");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", io.resp_valid, 1'b1);
            check("hold_data", io.resp_data, 32'd54);
            check("hold_rd", {27'd0, io.resp_rd}, 32'd21);
            check("hold_busy", io.busy, 1'b1);
            check("hold_req_ready", io.req_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        io.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_busy", io.busy, 1'b0);
        check("hold_release_valid", io.resp_valid, 1'b0);
        check("hold_release_req_ready", io.req_ready, 1'b1);

        // Flush at iteration 15
        start_raw(3'b001, 32'd123, 32'd456);
        repeat (15) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_req_ready_low", io.req_ready, 1'b0);
        check("flush_busy_before", io.busy, 1'b1);
        @(posedge clk);
        #1;
        check("flush_busy_after", io.busy, 1'b0);
        check("flush_resp_valid", io.resp_valid, 1'b0);
        io.req_valid = 1'b1;
        io.req_func3 = 3'b000;
        @(posedge clk);
        #1;
        check("flush_req_not_accepted", io.busy, 1'b0);
        io.req_valid = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_release_req_ready", io.req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Reset mid-iteration
        start_raw(3'b100, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", io.busy, 1'b0);
        check("midrst_resp_valid", io.resp_valid, 1'b0);
        check("midrst_resp_data", io.resp_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(3'b000, 32'd3, 32'd4, 5'd22, 32'd12, 34, "post_reset_mul");
        issue(3'b101, 32'd1000, 32'd3, 5'd23, 32'd333, 34, "post_reset_divu");

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
